// File: rtl/noc_params.sv
// Shared NoC parameters: port/VC counts, VC id width and the output port type.
// Ports: none (package).
package noc_params;

    localparam int unsigned PORT_NUM = 5;
    localparam int unsigned VC_NUM   = 2;
    localparam int unsigned VC_SIZE  = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

    typedef enum logic [2:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        SOUTH = 3'd2,
        WEST  = 3'd3,
        EAST  = 3'd4
    } port_t;

endpackage

// File: rtl/vc_allocator_pkg.sv
// VC allocator local constants derived from the shared NoC parameters.
// Ports: none (package).
package vc_allocator_pkg;
    import noc_params::*;

    // Number of requesting input VCs, flattened as i*VC_NUM+c.
    localparam int unsigned AGENTS_NUM = PORT_NUM * VC_NUM;

endpackage

// File: rtl/vc_allocator_if.sv
// Handshake bundle between the input buffers and the VC allocator.
// Signals:
//   request_i  [PORT_NUM][VC_NUM]           input VC wants a downstream VC
//   out_port_i [PORT_NUM][VC_NUM] port_t    routed output port of that input VC
//   release_i  [PORT_NUM][VC_NUM]           downstream VC (port,vc) freed
//   vc_valid_o [PORT_NUM][VC_NUM]           grant, same cycle as request
//   vc_new_o   [PORT_NUM][VC_NUM][VC_SIZE]  granted downstream VC id
// Modports: master drives requests/releases, slave is the allocator.
interface vc_allocator_if;
    import noc_params::*;

    logic  [PORT_NUM-1:0][VC_NUM-1:0]              request_i;
    port_t [PORT_NUM-1:0][VC_NUM-1:0]              out_port_i;
    logic  [PORT_NUM-1:0][VC_NUM-1:0]              release_i;
    logic  [PORT_NUM-1:0][VC_NUM-1:0]              vc_valid_o;
    logic  [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] vc_new_o;

    modport master (
        output request_i,
        output out_port_i,
        output release_i,
        input  vc_valid_o,
        input  vc_new_o
    );

    modport slave (
        input  request_i,
        input  out_port_i,
        input  release_i,
        output vc_valid_o,
        output vc_new_o
    );

endinterface

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter for one downstream VC: picks the first eligible agent at
// or after the held pointer; the pointer moves past the winner on a grant.
// Ports:
//   clk, rst      clock, synchronous active-high reset (pointer to 0)
//   i_request     request vector, already gated by VC availability
//   i_mask        agents already granted by a lower VC this cycle
//   o_grant_c     combinational one-hot grant (all zero if none)
module round_robin_arbiter #(
    parameter int unsigned AGENTS_NUM      = 10,
    parameter int unsigned AGENTS_PTR_SIZE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AGENTS_NUM-1:0] i_request,
    input  logic [AGENTS_NUM-1:0] i_mask,
    output logic [AGENTS_NUM-1:0] o_grant_c
);

    localparam int unsigned IDX_W = (AGENTS_NUM > 1) ? $clog2(AGENTS_NUM) : 1;

    logic [AGENTS_PTR_SIZE-1:0] r_ptr;
    logic [AGENTS_PTR_SIZE-1:0] w_ptr_next;
    logic [AGENTS_NUM-1:0]      w_eligible;
    logic [IDX_W-1:0]           w_idx;
    logic                       w_found;

    // Scan from the pointer, wrapping, and take the first eligible agent.
    always_comb begin
        w_eligible = i_request & ~i_mask;
        o_grant_c  = '0;
        w_found    = 1'b0;
        w_idx      = '0;
        w_ptr_next = r_ptr;
        for (int unsigned s = 0; s < AGENTS_NUM; s++) begin
            w_idx = IDX_W'((32'(r_ptr) + s) % AGENTS_NUM);
            if (!w_found && w_eligible[w_idx]) begin
                w_found           = 1'b1;
                o_grant_c[w_idx]  = 1'b1;
                w_ptr_next        = AGENTS_PTR_SIZE'((32'(w_idx) + 1) % AGENTS_NUM);
            end
        end
    end

    // Pointer only moves when this VC actually grants.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= w_ptr_next;
        end
    end

endmodule

// File: rtl/vc_allocator.sv
// Downstream VC allocator: tracks free VCs per output port and grants them to
// requesting input VCs in the same cycle, one round-robin arbiter per (port,vc).
// Lower downstream VCs of a port resolve first and mask their winners from
// higher ones, so each input VC gets at most one grant per cycle.
// Ports:
//   clk      clock
//   rst      synchronous active-high reset (all VCs free, pointers 0)
//   bus      vc_allocator_if.slave: requests, routes, releases, grants
//   error_o  registered protocol-violation flag
// Optional: define VC_ALLOCATOR_ERROR_CHECK_EN to flag releases of free VCs and
// requests routed to a non-existent port; otherwise error_o is tied to 0.
module vc_allocator
    import noc_params::*;
    import vc_allocator_pkg::*;
#(
    parameter int unsigned AGENTS_PTR_SIZE = $clog2(PORT_NUM * VC_NUM)
) (
    input  logic            clk,
    input  logic            rst,
    vc_allocator_if.slave   bus,
    output logic            error_o
);

    logic [PORT_NUM-1:0][VC_NUM-1:0]                  r_available;
    logic [PORT_NUM-1:0][PORT_NUM-1:0][VC_NUM-1:0]    w_port_req;
    logic [PORT_NUM-1:0][VC_NUM-1:0]                  w_grant_all [PORT_NUM][VC_NUM];
    logic [PORT_NUM-1:0][VC_NUM-1:0]                  w_any_grant;
    logic [PORT_NUM-1:0][VC_NUM-1:0]                  w_vc_valid;
    logic [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0]     w_vc_new;

    // Per destination port, which input VCs are asking for it.
    always_comb begin
        w_port_req = '0;
        for (int unsigned p = 0; p < PORT_NUM; p++) begin
            for (int unsigned i = 0; i < PORT_NUM; i++) begin
                for (int unsigned c = 0; c < VC_NUM; c++) begin
                    w_port_req[p][i][c] = bus.request_i[i][c] &&
                                          (32'(bus.out_port_i[i][c]) == p);
                end
            end
        end
    end

    // Arbiter chain per port; each stage masks winners of the stages below it.
    for (genvar p = 0; p < PORT_NUM; p++) begin : g_port
        for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
            logic [PORT_NUM-1:0][VC_NUM-1:0] w_mask_in;
            logic [PORT_NUM-1:0][VC_NUM-1:0] w_req;
            logic [PORT_NUM-1:0][VC_NUM-1:0] w_grant;
            logic [PORT_NUM-1:0][VC_NUM-1:0] w_mask_out;

            if (v == 0) begin : g_first
                assign w_mask_in = '0;
            end else begin : g_next
                assign w_mask_in = g_vc[v-1].w_mask_out;
            end

            // A busy VC, or any cycle under reset, offers nothing.
            assign w_req      = (r_available[p][v] && !rst) ? w_port_req[p] : '0;
            assign w_mask_out = w_mask_in | w_grant;

            round_robin_arbiter #(
                .AGENTS_NUM      (AGENTS_NUM),
                .AGENTS_PTR_SIZE (AGENTS_PTR_SIZE)
            ) u_arb (
                .clk       (clk),
                .rst       (rst),
                .i_request (w_req),
                .i_mask    (w_mask_in),
                .o_grant_c (w_grant)
            );

            assign w_grant_all[p][v] = w_grant;
        end
    end

    // Fold arbiter grants back onto the input VCs.
    always_comb begin
        w_vc_valid  = '0;
        w_vc_new    = '0;
        w_any_grant = '0;
        for (int unsigned p = 0; p < PORT_NUM; p++) begin
            for (int unsigned v = 0; v < VC_NUM; v++) begin
                w_any_grant[p][v] = |w_grant_all[p][v];
                for (int unsigned i = 0; i < PORT_NUM; i++) begin
                    for (int unsigned c = 0; c < VC_NUM; c++) begin
                        if (w_grant_all[p][v][i][c]) begin
                            w_vc_valid[i][c] = 1'b1;
                            w_vc_new[i][c]   = VC_SIZE'(v);
                        end
                    end
                end
            end
        end
    end

    assign bus.vc_valid_o = w_vc_valid;
    assign bus.vc_new_o   = w_vc_new;

    // Grant and release never hit the same VC, so the order here is moot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_available <= '1;
        end else begin
            r_available <= (r_available & ~w_any_grant) | bus.release_i;
        end
    end

`ifdef VC_ALLOCATOR_ERROR_CHECK_EN
    logic r_error;
    logic w_bad_req;

    // A request routed past the last port can never be served.
    always_comb begin
        w_bad_req = 1'b0;
        for (int unsigned i = 0; i < PORT_NUM; i++) begin
            for (int unsigned c = 0; c < VC_NUM; c++) begin
                if (bus.request_i[i][c] && (32'(bus.out_port_i[i][c]) >= PORT_NUM)) begin
                    w_bad_req = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_error <= 1'b0;
        end else begin
            r_error <= (|(bus.release_i & r_available)) | w_bad_req;
        end
    end

    assign error_o = r_error;
`else
    assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_vc_allocator.sv
// Bench for vc_allocator: a per-cycle reference model of the allocation rules
// checked on every falling edge, plus directed scenarios with literal checks.
module tb_vc_allocator;
    import noc_params::*;

    localparam int AG = PORT_NUM * VC_NUM;
    localparam int PL = 0;
    localparam int PN = 1;
    localparam int PS = 2;
    localparam int PW = 3;
    localparam int PE = 4;

    logic clk;
    logic rst;
    logic error_o;

    vc_allocator_if bus();

    vc_allocator u_dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .error_o (error_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: free flags, pointers, pending error, last-cycle grants.
    bit m_avail [PORT_NUM][VC_NUM];
    int m_ptr   [PORT_NUM][VC_NUM];
    bit m_err;
    logic [PORT_NUM-1:0][VC_NUM-1:0] g_last;

    initial begin
        foreach (m_avail[p, v]) begin
            m_avail[p][v] = 1'b1;
            m_ptr[p][v]   = 0;
        end
        m_err  = 1'b0;
        g_last = '0;
    end

    // Model: derive expected grants from the allocation rules, compare, advance.
    always @(negedge clk) begin
        logic [PORT_NUM-1:0][VC_NUM-1:0] ev;
        int  en   [PORT_NUM][VC_NUM];
        int  win  [PORT_NUM][VC_NUM];
        bit  taken[AG];
        bit  err_n;
        int  k;
        int  i;
        int  c;
        ev = '0;
        foreach (en[a, b]) begin
            en[a][b]  = 0;
            win[a][b] = -1;
        end
        foreach (taken[a]) taken[a] = 1'b0;
        if (!rst) begin
            for (int p = 0; p < PORT_NUM; p++) begin
                for (int v = 0; v < VC_NUM; v++) begin
                    if (m_avail[p][v]) begin
                        for (int s = 0; s < AG; s++) begin
                            k = (m_ptr[p][v] + s) % AG;
                            i = k / VC_NUM;
                            c = k % VC_NUM;
                            if (bus.request_i[i][c] && int'(bus.out_port_i[i][c]) == p && !taken[k]) begin
                                taken[k]  = 1'b1;
                                ev[i][c]  = 1'b1;
                                en[i][c]  = v;
                                win[p][v] = k;
                                break;
                            end
                        end
                    end
                end
            end
        end

        n_vec++;
        if (bus.vc_valid_o !== ev) begin
            n_err++;
            $display("FAIL vc_valid t=%0t got %b want %b", $time, bus.vc_valid_o, ev);
        end
        for (int a = 0; a < PORT_NUM; a++) begin
            for (int b = 0; b < VC_NUM; b++) begin
                if (ev[a][b]) begin
                    n_vec++;
                    if (int'(bus.vc_new_o[a][b]) != en[a][b]) begin
                        n_err++;
                        $display("FAIL vc_new[%0d][%0d] t=%0t got %0d want %0d",
                                 a, b, $time, bus.vc_new_o[a][b], en[a][b]);
                    end
                end
            end
        end
        n_vec++;
        if (error_o !== m_err) begin
            n_err++;
            $display("FAIL error_o t=%0t got %b want %b", $time, error_o, m_err);
        end

        err_n = 1'b0;
        if (rst) begin
            foreach (m_avail[p, v]) begin
                m_avail[p][v] = 1'b1;
                m_ptr[p][v]   = 0;
            end
        end else begin
`ifdef VC_ALLOCATOR_ERROR_CHECK_EN
            foreach (m_avail[p, v])
                if (bus.release_i[p][v] && m_avail[p][v]) err_n = 1'b1;
            foreach (m_avail[p, v])
                if (bus.request_i[p][v] && int'(bus.out_port_i[p][v]) >= PORT_NUM) err_n = 1'b1;
`endif
            foreach (m_avail[p, v]) begin
                if (win[p][v] >= 0) begin
                    m_avail[p][v] = 1'b0;
                    m_ptr[p][v]   = (win[p][v] + 1) % AG;
                end
                if (bus.release_i[p][v]) m_avail[p][v] = 1'b1;
            end
        end
        m_err  = err_n;
        g_last = ev;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got %0d want %0d", nm, $time, act, exp);
        end
    endtask

    // Advance one cycle; granted requesters drop, release pulses end.
    task automatic step();
        @(posedge clk);
        #1;
        bus.request_i = bus.request_i & ~g_last;
        bus.release_i = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.request_i = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic req(input int i, input int c, input int p);
        bus.request_i[i][c]  = 1'b1;
        bus.out_port_i[i][c] = port_t'(p);
    endtask

    initial begin
        rst            = 1'b1;
        bus.request_i  = '0;
        bus.release_i  = '0;
        bus.out_port_i = '{default: LOCAL};
        step();
        #2;
        chk("rst_valid", 32'(bus.vc_valid_o), 0);
        chk("rst_error", 32'(error_o), 0);

        // Single request to EAST, then proof that EAST vc0 is now taken.
        do_reset();
        req(0, 0, PE);
        #2;
        chk("s1_valid00", 32'(bus.vc_valid_o[0][0]), 1);
        chk("s1_new00", 32'(bus.vc_new_o[0][0]), 0);
        step();
        req(1, 0, PE);
        #2;
        chk("s1_new10_after", 32'(bus.vc_new_o[1][0]), 1);
        step();

        // Three requesters, two VCs on EAST.
        do_reset();
        req(0, 0, PE); req(1, 0, PE); req(2, 0, PE);
        #2;
        chk("s2_valid00", 32'(bus.vc_valid_o[0][0]), 1);
        chk("s2_new00", 32'(bus.vc_new_o[0][0]), 0);
        chk("s2_valid10", 32'(bus.vc_valid_o[1][0]), 1);
        chk("s2_new10", 32'(bus.vc_new_o[1][0]), 1);
        chk("s2_valid20", 32'(bus.vc_valid_o[2][0]), 0);
        step(); #2; chk("s2_stall20", 32'(bus.vc_valid_o[2][0]), 0);
        step(); bus.release_i[PE][0] = 1'b1;
        #2; chk("s2_relcyc20", 32'(bus.vc_valid_o[2][0]), 0);
        step(); #2;
        chk("s2_late20", 32'(bus.vc_valid_o[2][0]), 1);
        chk("s2_late_new20", 32'(bus.vc_new_o[2][0]), 0);
        step();

        // Round-robin alternation on NORTH with one free VC.
        do_reset();
        req(3, 0, PN); req(3, 1, PN);
        #2;
        chk("s3_new30", 32'(bus.vc_new_o[3][0]), 0);
        chk("s3_new31", 32'(bus.vc_new_o[3][1]), 1);
        step();
        bus.release_i[PN][0] = 1'b1;
        req(1, 0, PN); req(2, 0, PN);
        #2; chk("s3_relcyc", 32'(bus.vc_valid_o), 0);
        step(); #2;
        chk("s3_g1_10", 32'(bus.vc_valid_o[1][0]), 1);
        chk("s3_g1_20", 32'(bus.vc_valid_o[2][0]), 0);
        step(); bus.release_i[PN][0] = 1'b1;
        step(); #2;
        chk("s3_g2_20", 32'(bus.vc_valid_o[2][0]), 1);
        step(); bus.release_i[PN][0] = 1'b1; req(1, 0, PN);
        step(); #2;
        chk("s3_g3_10", 32'(bus.vc_valid_o[1][0]), 1);
        step();

        // WEST fully allocated: stall until vc1 is released.
        do_reset();
        req(0, 0, PW); req(0, 1, PW);
        step();
        req(4, 1, PW);
        for (int n = 0; n < 3; n++) begin
            #2; chk("s4_stall41", 32'(bus.vc_valid_o[4][1]), 0);
            step();
        end
        bus.release_i[PW][1] = 1'b1;
        #2; chk("s4_relcyc41", 32'(bus.vc_valid_o[4][1]), 0);
        step(); #2;
        chk("s4_valid41", 32'(bus.vc_valid_o[4][1]), 1);
        chk("s4_new41", 32'(bus.vc_new_o[4][1]), 1);
        step();

        // Reset while SOUTH is fully allocated.
        do_reset();
        req(1, 1, PS); req(2, 1, PS);
        step();
        req(3, 0, PS);
        rst = 1'b1;
        #2; chk("s5_rst_valid30", 32'(bus.vc_valid_o[3][0]), 0);
        step();
        rst = 1'b0;
        #2;
        chk("s5_valid30", 32'(bus.vc_valid_o[3][0]), 1);
        chk("s5_new30", 32'(bus.vc_new_o[3][0]), 0);
        step();

        // Release of an already-free VC.
        do_reset();
        bus.release_i[PL][0] = 1'b1;
        step();
        req(0, 0, PL);
        #2;
`ifdef VC_ALLOCATOR_ERROR_CHECK_EN
        chk("s6_error_set", 32'(error_o), 1);
`else
        chk("s6_error_off", 32'(error_o), 0);
`endif
        chk("s6_still_free", 32'(bus.vc_valid_o[0][0]), 1);
        step(); #2;
        chk("s6_error_clr", 32'(error_o), 0);
        step();

        // Mixed traffic, releases only of allocated VCs, one mid-run reset.
        do_reset();
        for (int n = 0; n < 80; n++) begin
            for (int i = 0; i < PORT_NUM; i++)
                for (int c = 0; c < VC_NUM; c++)
                    if (!bus.request_i[i][c] && $urandom_range(2) == 0)
                        req(i, c, int'($urandom_range(PORT_NUM - 1)));
            for (int p = 0; p < PORT_NUM; p++)
                for (int v = 0; v < VC_NUM; v++)
                    if (!m_avail[p][v] && $urandom_range(3) == 0)
                        bus.release_i[p][v] = 1'b1;
            rst = (n == 40);
            step();
        end
        rst = 1'b0;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vc_allocator.md
VC_ALLOCATOR -- requirements
Module: vc_allocator

Interface
REQ-001 Parameter AGENTS_PTR_SIZE, default $clog2(PORT_NUM*VC_NUM), width of round-robin pointer per output VC.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 request_i  input  [PORT_NUM][VC_NUM]  input-VC request for downstream VC; driven from input buffer vc_request_o.
REQ-005 out_port_i  input  port_t [PORT_NUM][VC_NUM]  routed output port of each requesting input VC.
REQ-006 release_i  input  [PORT_NUM][VC_NUM]  pulse: downstream VC v on output port p freed after its tail flit was sent.
REQ-007 vc_valid_o  output  [PORT_NUM][VC_NUM]  grant to input VC, same cycle as request; feeds input buffer vc_valid_i.
REQ-008 vc_new_o  output  [PORT_NUM][VC_NUM][VC_SIZE]  allocated downstream VC id; meaningful only while vc_valid_o is 1.
REQ-009 error_o  output  1  registered protocol-violation flag.

Function
REQ-010 The block SHALL hold available[p][v], one bit per output port p and downstream VC v, with 1 meaning free.
REQ-011 Each cycle, for each (p,v) with available[p][v]=1, the block SHALL arbitrate combinationally among input VCs (i,c) with request_i[i][c]=1 and out_port_i[i][c]=p.
REQ-012 Output VCs of one port SHALL be resolved in ascending v; an input VC granted by a lower v SHALL be masked from higher v in the same cycle.
REQ-013 An input VC SHALL receive at most one grant per cycle; vc_valid_o and vc_new_o SHALL be combinational, latency 0.
REQ-014 Arbitration per (p,v) SHALL be round-robin over flattened index i*VC_NUM+c, starting at ptr[p][v]; on grant ptr SHALL become winner+1, wrapping PORT_NUM*VC_NUM-1 to 0.
REQ-015 ptr[p][v] SHALL be unchanged when (p,v) issues no grant.
REQ-016 A grant of (p,v) SHALL clear available[p][v] at the next edge.
REQ-017 release_i[p][v]=1 SHALL set available[p][v] at the next edge; the released VC SHALL become grantable no earlier than the cycle after release.
REQ-018 Grant and release of the same (p,v) cannot coincide (grant requires available=1); release of an already-free VC SHALL leave available at 1.
REQ-019 When no downstream VC of port p is free, requests to p SHALL stall with vc_valid_o=0 and no state change.
REQ-020 Requests SHALL be level; a requester holds request_i until granted, and after its grant it drops request_i in the following cycle.

Reset
REQ-021 rst=1 at a clock edge SHALL set every available bit to 1, every ptr to 0, and error_o to 0; this applies mid-operation and discards all allocations.
REQ-022 vc_valid_o SHALL be 0 during any cycle in which rst is 1.

Configuration
REQ-023 Macro VC_ALLOCATOR_ERROR_CHECK_EN: when defined, error_o SHALL register 1 for one cycle after release_i on a free VC or a request with out_port_i outside port_t range; when undefined, error_o SHALL be constant 0 and the check logic SHALL be absent.

Structure
REQ-024 PORT_NUM, VC_NUM, VC_SIZE and port_t SHALL come from the shared package noc_params; the block SHALL add no new package types.
REQ-025 Per-(p,v) arbitration SHALL be one sub-module, round_robin_arbiter: request vector plus mask in, one-hot grant out, pointer held internally with synchronous reset.

Verification
REQ-026 Reset, then request_i[0][0]=1 with out_port_i=EAST -> vc_valid_o[0][0]=1 and vc_new_o[0][0]=0 in the same cycle; available[EAST][0]=0 on the next cycle.
REQ-027 With VC_NUM=2, three input VCs request EAST in one cycle -> two grants with vc_new 0 and 1 going to the lowest indices; the third VC is granted only after release_i[EAST][x].
REQ-028 Two input VCs (1,0) and (2,0) hold requests on NORTH with one VC free, and the VC is released after each grant -> grants alternate (1,0),(2,0),(1,0).
REQ-029 Port WEST fully allocated plus a request -> vc_valid_o=0 every cycle; release_i[WEST][1] -> grant vc_new=1 one cycle later.
REQ-030 rst is asserted while two VCs are allocated -> all VCs are free next cycle and a new request is granted vc_new=0.
REQ-031 With VC_ALLOCATOR_ERROR_CHECK_EN defined, release_i on a free VC -> error_o=1 for exactly one cycle.
